fir_lane_packer: RTL and testbench
==================================

# fir_lane_packer

Source-side packer for the dual-channel, 8-lane decimating FIR (`fir_troy`). It accepts one time-sample per beat for all channels and assembles PSAMPLES consecutive samples per channel into one wide AXI-Stream beat. That beat drives the FIR's `s_tvalid`/`s_tready`/`s_tdata` port directly. A double buffer lets the block sustain one input sample per clock under continuous downstream readiness, and a `tlast` flush zero-pads partial words.

## Interface

- `CHANNELS`, 2: number of independent channels per input beat.
- `DATA_WIDTH`, 16: signed sample width per channel.
- `PSAMPLES`, 8: samples (lanes) per channel per output beat; power of two, ≥2.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_tvalid`  in  1  input sample valid.
- `in_tready`  out  1  input ready.
- `in_tdata`  in  CHANNELS*DATA_WIDTH  one time-sample; channel c at `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `in_tlast`  in  1  final sample of a burst; forces emission of the current word.
- `m_tvalid`  out  1  packed beat valid (to FIR `s_tvalid`).
- `m_tready`  in  1  downstream ready (from FIR `s_tready`).
- `m_tdata`  out  CHANNELS*DATA_WIDTH*PSAMPLES  packed beat; channel c, lane k at `[(c*PSAMPLES+k)*DATA_WIDTH +: DATA_WIDTH]`, lane 0 oldest. With the defaults, ch1 occupies [255:128] and ch0 occupies [127:0].
- `m_tlast`  out  1  beat was closed by `in_tlast`.
- `lane_cnt`  out  $clog2(PSAMPLES)  lanes filled in the assembly word (status).

## Operation

- The block has two stages: an assembly register (`acc`, lane counter `cnt`) and an output register (`m_tdata`/`m_tvalid`/`m_tlast`).
- Input accept is `in_tvalid && in_tready`. On accept, the block writes each channel's sample into lane `cnt` of `acc`.
- The word closes when an accept occurs with `cnt == PSAMPLES-1` or `in_tlast == 1`.
  - On close, the word goes to the output register with the just-accepted sample included.
  - Unfilled lanes are zero.
  - `m_tlast` is set to `in_tlast`.
  - `acc` is cleared and `cnt` returns to 0.
- A non-closing accept increments `cnt`.
- `in_tready = !rst && !(close_pending && m_tvalid && !m_tready)`, where `close_pending = (cnt == PSAMPLES-1) || in_tlast`. Ready drops only when a closing sample would overwrite an undrained output beat. This is a combinational path from `m_tready`/`in_tlast`, and it is intended.
- Output register update:
  - load on close;
  - else clear `m_tvalid` on `m_tvalid && m_tready`;
  - else hold.
  - `m_tdata`/`m_tlast` are stable while `m_tvalid && !m_tready`.
- Close coinciding with a downstream drain in the same cycle: the new word loads and `m_tvalid` stays 1 with no gap.
- `in_tlast` on lane PSAMPLES-1 produces exactly one beat with `m_tlast = 1` and no extra zero beat.
- `in_tlast` with `cnt == 0` emits a beat containing lane 0 plus zero lanes.
- No arithmetic is performed on samples. Bits pass through unchanged.

## Timing

- Reset, synchronous: `cnt = 0`, `acc = 0`, `m_tvalid = 0`, `m_tdata = 0`, `m_tlast = 0`, `lane_cnt = 0`. `in_tready = 0` while `rst` is high and 1 in the first cycle after.
- Reset mid-word discards the partial `acc` and any pending output beat. Nothing is emitted afterward.
- Latency: the beat is valid the cycle after the closing sample is accepted.
- Throughput: with `m_tready` held 1, `in_tready` is never deasserted. The block produces 1 beat per PSAMPLES input cycles.
- Backpressure: `in_tready` falls only in a cycle where a close is pending and the output is held. It rises in the same cycle that `m_tready` returns.
- `lane_cnt` mirrors `cnt`, registered.

## Test plan

- Ramp: 8 accepts with ch0 = 1..8 and ch1 = 0x101..0x108, `m_tready = 1` → one beat, 1 cycle after the 8th sample. `m_tdata[15:0] = 1`, `[127:112] = 8`, `[143:128] = 0x101`, `[255:240] = 0x108`, `m_tlast = 0`.
- Continuous: 64 consecutive samples, `m_tready = 1` → `in_tready` is 1 every cycle, 8 beats arrive 8 cycles apart, and the data matches the reference packing model.
- Backpressure: stream 16 samples with `m_tready = 0` for cycles 0–20 → `in_tready = 0` from the 16th sample until `m_tready` rises. Word 1 is held stable, then word 2 follows on the next cycle. No loss or duplication.
- Flush: 3 samples (0x7fff, 0x1234, 0x8000) with `in_tlast` on the 3rd → lanes 0–2 carry those values, lanes 3–7 are 0 on both channels, `m_tlast = 1`, and `cnt` returns to 0.
- Reset mid-word: 5 samples accepted, then `rst` for 1 cycle, then 8 new samples → exactly one beat, containing only the new samples.
- `tlast` on lane 7 → exactly one beat with `m_tlast = 1`, and `m_tvalid` is not reasserted afterward without new input.

Source files
------------

// File: rtl/fir_lane_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : fir_lane_packer_if
// Brief    : Sample-in / packed-beat-out handshake bundle for fir_lane_packer.
// Revision : 1.0
// ============================================================================
interface fir_lane_packer_if #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int PSAMPLES   = 8
);
    logic                                    in_tvalid;
    logic                                    in_tready;
    logic [CHANNELS*DATA_WIDTH-1:0]          in_tdata;
    logic                                    in_tlast;
    logic                                    m_tvalid;
    logic                                    m_tready;
    logic [CHANNELS*DATA_WIDTH*PSAMPLES-1:0] m_tdata;
    logic                                    m_tlast;

    // Packer side: consumes samples, produces packed beats.
    modport slave (
        input  in_tvalid, in_tdata, in_tlast, m_tready,
        output in_tready, m_tvalid, m_tdata, m_tlast
    );

    modport master (
        output in_tvalid, in_tdata, in_tlast, m_tready,
        input  in_tready, m_tvalid, m_tdata, m_tlast
    );
endinterface
`default_nettype wire

// File: rtl/fir_lane_packer.sv
`default_nettype none
// ============================================================================
// Module   : fir_lane_packer
// Brief    : Packs PSAMPLES consecutive samples per channel into one wide beat.
// Revision : 1.0
// ============================================================================
module fir_lane_packer #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 16,
    parameter int PSAMPLES   = 8
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    fir_lane_packer_if.slave                 bus,
    output logic [$clog2(PSAMPLES)-1:0]      lane_cnt
);
    localparam int CNT_W = $clog2(PSAMPLES);
    localparam int OUT_W = CHANNELS * DATA_WIDTH * PSAMPLES;

    logic [OUT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_m_tvalid;
    logic [OUT_W-1:0] r_m_tdata;
    logic             r_m_tlast;

    logic             w_close_pending;
    logic             w_ready;
    logic             w_accept;
    logic             w_close;
    logic [OUT_W-1:0] w_word;

    // Ready only drops when a closing sample would overwrite an undrained beat.
    assign w_close_pending = (r_cnt == CNT_W'(PSAMPLES - 1)) || bus.in_tlast;
    assign w_ready         = !rst && !(w_close_pending && r_m_tvalid && !bus.m_tready);
    assign w_accept        = bus.in_tvalid && w_ready;
    assign w_close         = w_accept && w_close_pending;

    always_comb begin
        w_word = r_acc;
        for (int c = 0; c < CHANNELS; c++) begin
            w_word[(c*PSAMPLES + int'(r_cnt))*DATA_WIDTH +: DATA_WIDTH] =
                bus.in_tdata[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tdata  <= '0;
            r_m_tlast  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_close_pending) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_word;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            // A close in the same cycle as a drain reloads with no bubble.
            if (w_close) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_word;
                r_m_tlast  <= bus.in_tlast;
            end else if (r_m_tvalid && bus.m_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    assign bus.in_tready = w_ready;
    assign bus.m_tvalid  = r_m_tvalid;
    assign bus.m_tdata   = r_m_tdata;
    assign bus.m_tlast   = r_m_tlast;
    assign lane_cnt      = r_cnt;
endmodule
`default_nettype wire

// File: tb/tb_fir_lane_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_lane_packer
// Brief    : Directed, table-driven bench for fir_lane_packer.
// Revision : 1.0
// ============================================================================
module tb_fir_lane_packer;
    localparam int CH = 2;
    localparam int DW = 16;
    localparam int PS = 8;
    localparam int OW = CH * DW * PS;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] d0;
        logic [15:0] d1;
        logic        last;
        logic        rdy;
        logic        e_ready;
        logic        e_mvalid;
        logic        e_mlast;
        logic [2:0]  e_cnt;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [2:0] lane_cnt;

    fir_lane_packer_if #(.CHANNELS(CH), .DATA_WIDTH(DW), .PSAMPLES(PS)) bus ();

    fir_lane_packer #(.CHANNELS(CH), .DATA_WIDTH(DW), .PSAMPLES(PS)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .lane_cnt (lane_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int beats    = 0;

    // Lane-array reference of the assembly word and the output register.
    logic [15:0]   m_acc [CH][PS];
    int            m_cnt;
    logic          m_ov;
    logic [OW-1:0] m_od;
    logic          m_ol;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic vld, input logic [15:0] d0,
                                input logic [15:0] d1, input logic last, input logic rdy,
                                input logic e_ready, input logic e_mvalid, input logic e_mlast,
                                input logic [2:0] e_cnt);
        vec_t v;
        v.rst = r; v.vld = vld; v.d0 = d0; v.d1 = d1; v.last = last; v.rdy = rdy;
        v.e_ready = e_ready; v.e_mvalid = e_mvalid; v.e_mlast = e_mlast; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < PS; k++) m_acc[c][k] = '0;
        m_cnt = 0;
        m_ov  = 1'b0;
        m_od  = '0;
        m_ol  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic          hs;
        logic          acc;
        logic [OW-1:0] w;
        rst           = v.rst;
        bus.in_tvalid = v.vld;
        bus.in_tdata  = {v.d1, v.d0};
        bus.in_tlast  = v.last;
        bus.m_tready  = v.rdy;
        #1;
        chk("in_tready", OW'(bus.in_tready), OW'(v.e_ready));
        hs  = m_ov && v.rdy;
        acc = v.vld && v.e_ready && !v.rst;
        @(posedge clk);
        #1;
        if (v.rst) begin
            model_reset();
        end else begin
            if (hs) begin
                m_ov = 1'b0;
                beats++;
            end
            if (acc) begin
                m_acc[0][m_cnt] = v.d0;
                m_acc[1][m_cnt] = v.d1;
                if (m_cnt == PS - 1 || v.last) begin
                    w = '0;
                    for (int c = 0; c < CH; c++)
                        for (int k = 0; k < PS; k++) w[(c*PS+k)*DW +: DW] = m_acc[c][k];
                    m_od = w;
                    m_ol = v.last;
                    m_ov = 1'b1;
                    for (int c = 0; c < CH; c++)
                        for (int k = 0; k < PS; k++) m_acc[c][k] = '0;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        chk("m_tvalid", OW'(bus.m_tvalid), OW'(v.e_mvalid));
        if (v.e_mvalid) chk("m_tlast", OW'(bus.m_tlast), OW'(v.e_mlast));
        chk("lane_cnt", OW'(lane_cnt), OW'(v.e_cnt));
        chk("m_tdata_model", bus.m_tdata, m_od);
        chk("m_tlast_model", OW'(bus.m_tlast), OW'(m_ol));
    endtask

    initial begin
        logic [15:0] fl0 [3];
        logic [15:0] fl1 [3];
        logic [15:0] e;
        logic [2:0]  ec;
        int          b0;
        int          idx;

        model_reset();
        rst = 1'b1;
        bus.in_tvalid = 1'b0;
        bus.in_tdata  = '0;
        bus.in_tlast  = 1'b0;
        bus.m_tready  = 1'b0;

        // Reset, tlast on lane 7 with idle tail, tlast with cnt == 0.
        tbl.push_back(mk(1, 0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 16'(16'h0200 + i), 16'(16'h0300 + i), i == 7, 1,
                             1, i == 7, i == 7, 3'((i + 1) % 8)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 0, 3'd0));
        tbl.push_back(mk(0, 1, 16'h5555, 16'haaaa, 1, 1, 1, 1, 1, 3'd0));
        tbl.push_back(mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 0, 3'd0));
        b0 = beats;
        foreach (tbl[i]) run_vec(tbl[i]);
        chk("table_beats", OW'(beats - b0), OW'(2));

        // Ramp
        for (int i = 0; i < 8; i++)
            run_vec(mk(0, 1, 16'(i + 1), 16'(16'h0101 + i), 0, 1, 1, i == 7, 0, 3'((i + 1) % 8)));
        chk("ramp_c0_l0", OW'(bus.m_tdata[15:0]), OW'(16'h0001));
        chk("ramp_c0_l7", OW'(bus.m_tdata[127:112]), OW'(16'h0008));
        chk("ramp_c1_l0", OW'(bus.m_tdata[143:128]), OW'(16'h0101));
        chk("ramp_c1_l7", OW'(bus.m_tdata[255:240]), OW'(16'h0108));
        chk("ramp_tlast", OW'(bus.m_tlast), OW'(1'b0));
        run_vec(mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 0, 3'd0));

        // Flush with zero padding
        fl0 = '{16'h7fff, 16'h1234, 16'h8000};
        fl1 = '{16'h8001, 16'habcd, 16'h0042};
        for (int i = 0; i < 3; i++)
            run_vec(mk(0, 1, fl0[i], fl1[i], i == 2, 1, 1, i == 2, i == 2, 3'((i + 1) % 3)));
        for (int k = 0; k < PS; k++) begin
            e = (k < 3) ? fl0[k] : 16'h0;
            chk("flush_c0", OW'(bus.m_tdata[k*DW +: DW]), OW'(e));
            e = (k < 3) ? fl1[k] : 16'h0;
            chk("flush_c1", OW'(bus.m_tdata[(PS+k)*DW +: DW]), OW'(e));
        end
        chk("flush_tlast", OW'(bus.m_tlast), OW'(1'b1));
        chk("flush_cnt", OW'(lane_cnt), OW'(3'd0));
        run_vec(mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 0, 3'd0));

        // Continuous stream, ready never drops
        b0 = beats;
        for (int i = 0; i < 64; i++)
            run_vec(mk(0, 1, 16'(i * 3 + 7), 16'(16'hf000 ^ i), 0, 1, 1, (i % 8) == 7, 0,
                       3'((i + 1) % 8)));
        run_vec(mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 0, 3'd0));
        chk("cont_beats", OW'(beats - b0), OW'(8));

        // Backpressure: m_tready low for cycles 0..20
        b0 = beats;
        for (int c = 0; c < 23; c++) begin
            idx = (c < 15) ? c : 15;
            if (c < 7)       ec = 3'(c + 1);
            else if (c == 7) ec = 3'd0;
            else if (c < 15) ec = 3'(c - 7);
            else if (c < 21) ec = 3'd7;
            else             ec = 3'd0;
            run_vec(mk(0, c <= 21, 16'(16'h4000 + idx), 16'(16'h6000 + idx), 0, c >= 21,
                       !(c >= 15 && c <= 20), c >= 7 && c <= 21, 0, ec));
        end
        chk("bp_beats", OW'(beats - b0), OW'(2));

        // Reset mid-word discards the partial word
        for (int i = 0; i < 5; i++)
            run_vec(mk(0, 1, 16'(16'h00a0 + i), 16'(16'h00b0 + i), 0, 1, 1, 0, 0, 3'(i + 1)));
        run_vec(mk(1, 1, 16'h00ee, 16'h00ee, 0, 1, 0, 0, 0, 3'd0));
        b0 = beats;
        for (int i = 0; i < 8; i++)
            run_vec(mk(0, 1, 16'(16'h00c0 + i), 16'(16'h00d0 + i), 0, 1, 1, i == 7, 0,
                       3'((i + 1) % 8)));
        chk("rst_new_l0", OW'(bus.m_tdata[15:0]), OW'(16'h00c0));
        chk("rst_new_c1l7", OW'(bus.m_tdata[255:240]), OW'(16'h00d7));
        run_vec(mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 0, 3'd0));
        run_vec(mk(0, 0, 16'h0, 16'h0, 0, 1, 1, 0, 0, 3'd0));
        chk("rst_beats", OW'(beats - b0), OW'(1));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
`default_nettype wire
